// File: rtl/wave_sel_pkg.sv
// Shared definitions for the waveform select controller.
package wave_sel_pkg;

   localparam int unsigned NUM_WAVES = 7;
   localparam int unsigned SEL_W     = 3;

   localparam logic [SEL_W-1:0] WAVE_RHOMB   = 3'd0;
   localparam logic [SEL_W-1:0] WAVE_SINE    = 3'd1;
   localparam logic [SEL_W-1:0] WAVE_SQUARE  = 3'd2;
   localparam logic [SEL_W-1:0] WAVE_TRI     = 3'd3;
   localparam logic [SEL_W-1:0] WAVE_SAW     = 3'd4;
   localparam logic [SEL_W-1:0] WAVE_FWR     = 3'd5;
   localparam logic [SEL_W-1:0] WAVE_MODSINE = 3'd6;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   // Step forward through the waveforms, wrapping the last one to the first.
   function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] s);
      return (s == SEL_W'(NUM_WAVES - 1)) ? WAVE_RHOMB : s + SEL_W'(1);
   endfunction

   // Step backward through the waveforms, wrapping the first one to the last.
   function automatic logic [SEL_W-1:0] sel_prev(input logic [SEL_W-1:0] s);
      return (s == WAVE_RHOMB) ? WAVE_MODSINE : s - SEL_W'(1);
   endfunction

endpackage

// File: rtl/wave_sel_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter, press pulse.
module btn_debounce #(
   parameter int unsigned DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press
);

   localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             press_q, press_d;

   // Synchronise, then accept a new level once it has differed from the
   // accepted one for DEB_CYCLES consecutive samples; pulse on accepted rise.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Debouncer state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/wave_sel_ctrl.sv
// Waveform mux select controller: buttons and auto-scan, applied on period boundaries.
module wave_sel_ctrl
   import wave_sel_pkg::*;
#(
   parameter int unsigned DEB_CYCLES    = 50000,
   parameter int unsigned DWELL_PERIODS = 16,
   parameter int unsigned WAIT_MAX      = 65535
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_next,
   input  logic             btn_prev,
   input  logic             auto_en,
   input  logic             phase_wrap,
   output logic [SEL_W-1:0] sel,
   output logic             sel_pending,
   output logic             sel_changed
);

   localparam int unsigned DW_W   = (DWELL_PERIODS > 1) ? $clog2(DWELL_PERIODS) : 1;
   localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

   logic              next_press, prev_press;
   state_t            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [SEL_W-1:0]  target_q, target_d;
   logic [DW_W-1:0]   dwell_q, dwell_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              pending_q, pending_d;
   logic              changed_q, changed_d;

   logic              ev_next_c, ev_prev_c, ev_any_c;
   logic [SEL_W-1:0]  tgt_step_c;
   logic [WAIT_W-1:0] wait_inc_c;
   logic              apply_c;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_next),
      .press   (next_press)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_prev),
      .press   (prev_press)
   );

   // Event qualification, target step and apply condition shared by both comb blocks.
   always_comb begin
      ev_next_c  = next_press & ~prev_press;
      ev_prev_c  = prev_press & ~next_press;
      ev_any_c   = ev_next_c | ev_prev_c;
      tgt_step_c = ev_next_c ? sel_next(target_q) :
                   ev_prev_c ? sel_prev(target_q) : target_q;
      wait_inc_c = wait_q + WAIT_W'(1);
      apply_c    = phase_wrap | (wait_inc_c == WAIT_W'(WAIT_MAX));
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a button request waits in PENDING until a wrap or timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (ev_any_c) state_d = ST_PENDING;
         ST_PENDING: if (apply_c)  state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Datapath and outputs: target/dwell/wait counters and select updates.
   always_comb begin
      target_d = target_q;
      dwell_d  = dwell_q;
      wait_d   = wait_q;
      sel_d    = sel_q;
      case (state_q)
         ST_IDLE: begin
            if (ev_any_c) begin
               target_d = tgt_step_c;
               wait_d   = '0;
            end else if (auto_en && phase_wrap) begin
               if (dwell_q == DW_W'(DWELL_PERIODS - 1)) begin
                  sel_d    = sel_next(sel_q);
                  target_d = sel_next(sel_q);
                  dwell_d  = '0;
               end else begin
                  dwell_d = dwell_q + DW_W'(1);
               end
            end
         end
         ST_PENDING: begin
            target_d = tgt_step_c;
            wait_d   = wait_inc_c;
            if (apply_c) begin
               sel_d   = tgt_step_c;
               dwell_d = '0;
               wait_d  = '0;
            end
         end
         default: begin
            target_d = sel_q;
         end
      endcase
      changed_d = (sel_d != sel_q);
      pending_d = (state_d == ST_PENDING);
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q     <= WAVE_RHOMB;
         target_q  <= WAVE_RHOMB;
         dwell_q   <= '0;
         wait_q    <= '0;
         pending_q <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         sel_q     <= sel_d;
         target_q  <= target_d;
         dwell_q   <= dwell_d;
         wait_q    <= wait_d;
         pending_q <= pending_d;
         changed_q <= changed_d;
      end
   end

   assign sel         = sel_q;
   assign sel_pending = pending_q;
   assign sel_changed = changed_q;

endmodule

// File: tb/tb_wave_sel_ctrl.sv
// Directed self-checking bench for wave_sel_ctrl (DEB=4, DWELL=3, WAIT=20).
module tb_wave_sel_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_next = 1'b0;
   logic       btn_prev = 1'b0;
   logic       auto_en = 1'b0;
   logic       phase_wrap = 1'b0;
   logic [2:0] sel;
   logic       sel_pending;
   logic       sel_changed;

   int checks = 0;
   int errors = 0;
   int rise_cnt = 0;
   int chg_cnt = 0;
   logic pend_prev = 1'b0;
   logic seen7 = 1'b0;

   wave_sel_ctrl #(
      .DEB_CYCLES    (4),
      .DWELL_PERIODS (3),
      .WAIT_MAX      (20)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_next    (btn_next),
      .btn_prev    (btn_prev),
      .auto_en     (auto_en),
      .phase_wrap  (phase_wrap),
      .sel         (sel),
      .sel_pending (sel_pending),
      .sel_changed (sel_changed)
   );

   always #5 clk = ~clk;

   // Output observers sampled on the falling edge.
   always @(negedge clk) begin
      if (sel == 3'd7) seen7 <= 1'b1;
      if (sel_pending && !pend_prev) rise_cnt <= rise_cnt + 1;
      if (sel_changed) chg_cnt <= chg_cnt + 1;
      pend_prev <= sel_pending;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Clean press: raw high for 4 sampled edges, then low for 4.
   task automatic press(input logic nxt, input logic prv);
      btn_next = nxt;
      btn_prev = prv;
      repeat (4) step();
      btn_next = 1'b0;
      btn_prev = 1'b0;
      repeat (4) step();
   endtask

   task automatic wrap_pulse();
      phase_wrap = 1'b1;
      step();
      phase_wrap = 1'b0;
   endtask

   initial begin
      int base;
      int n;
      int exp_sel;

      repeat (3) step();
      check("rst_sel", 32'(sel), 0);
      check("rst_pending", 32'(sel_pending), 0);
      check("rst_changed", 32'(sel_changed), 0);
      rst_n = 1'b1;
      step();

      // 1. bouncy press, then wrap
      for (int i = 0; i < 6; i++) begin
         btn_next = (i % 2 == 0);
         step();
      end
      btn_next = 1'b1;
      repeat (10) step();
      check("t1_pending", 32'(sel_pending), 1);
      check("t1_sel_hold", 32'(sel), 0);
      wrap_pulse();
      check("t1_sel", 32'(sel), 1);
      check("t1_changed", 32'(sel_changed), 1);
      check("t1_pend_clr", 32'(sel_pending), 0);
      step();
      check("t1_changed_one", 32'(sel_changed), 0);
      repeat (4) step();
      btn_next = 1'b0;
      repeat (8) step();
      check("t1_one_event", 32'(rise_cnt), 1);
      wrap_pulse();
      check("t1_sel_stay", 32'(sel), 1);

      // 2. wrap-around in both directions
      press(1'b0, 1'b1);
      wrap_pulse();
      check("t2_prev_to0", 32'(sel), 0);
      press(1'b0, 1'b1);
      wrap_pulse();
      check("t2_prev_to6", 32'(sel), 6);
      press(1'b1, 1'b0);
      wrap_pulse();
      check("t2_next_to0", 32'(sel), 0);

      // 3. presses accumulate into one update
      press(1'b1, 1'b0);
      wrap_pulse();
      press(1'b1, 1'b0);
      wrap_pulse();
      check("t3_sel2", 32'(sel), 2);
      step();
      base = chg_cnt;
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      check("t3_pending", 32'(sel_pending), 1);
      check("t3_sel_hold", 32'(sel), 2);
      wrap_pulse();
      check("t3_sel5", 32'(sel), 5);
      repeat (3) step();
      check("t3_one_pulse", 32'(chg_cnt - base), 1);

      // 4. auto-scan every third wrap, then a press restarts the dwell
      auto_en = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         wrap_pulse();
         exp_sel = (5 + k / 3) % 7;
         check($sformatf("t4_auto%0d", k), 32'(sel), 32'(exp_sel));
         repeat (7) step();
      end
      wrap_pulse();
      check("t4_dwell1", 32'(sel), 1);
      press(1'b1, 1'b0);
      wrap_pulse();
      check("t4_press", 32'(sel), 2);
      repeat (7) step();
      wrap_pulse();
      repeat (7) step();
      wrap_pulse();
      check("t4_after2", 32'(sel), 2);
      repeat (7) step();
      wrap_pulse();
      check("t4_after3", 32'(sel), 3);
      auto_en = 1'b0;
      repeat (4) step();

      // 5. forced apply after WAIT_MAX cycles; simultaneous presses dropped
      btn_next = 1'b1;
      for (int i = 0; i < 30 && !sel_pending; i++) step();
      check("t5_enter", 32'(sel_pending), 1);
      n = 0;
      for (int i = 0; i < 40 && sel_pending; i++) begin
         n++;
         step();
      end
      check("t5_wait_len", 32'(n), 20);
      check("t5_forced_sel", 32'(sel), 4);
      check("t5_forced_chg", 32'(sel_changed), 1);
      btn_next = 1'b0;
      repeat (8) step();
      base = rise_cnt;
      press(1'b1, 1'b1);
      repeat (4) step();
      check("t5_both_drop", 32'(rise_cnt - base), 0);
      check("t5_both_pend", 32'(sel_pending), 0);
      wrap_pulse();
      check("t5_both_sel", 32'(sel), 4);

      // 6. asynchronous reset while pending with target 4
      press(1'b0, 1'b1);
      wrap_pulse();
      check("t6_sel3", 32'(sel), 3);
      press(1'b1, 1'b0);
      check("t6_pending", 32'(sel_pending), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_sel", 32'(sel), 0);
      check("t6_rst_pend", 32'(sel_pending), 0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      wrap_pulse();
      check("t6_post_sel", 32'(sel), 0);
      check("t6_post_chg", 32'(sel_changed), 0);
      check("t6_post_pend", 32'(sel_pending), 0);
      step();
      check("sel_never7", 32'(seen7), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
